seq_bcd_display: RTL

//  Sequential, parametrised signed/unsigned binary to 7-segment display driver.

---
 rtl/seq_bcd_display.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_bcd_display.sv
// Sequential binary-to-7-segment driver: captures a word, converts it to signed
// magnitude, runs a one-bit-per-clock double-dabble, then registers the segments.
module seq_bcd_display #(
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 3,
  parameter int BLANK_LEAD = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  signed_mode_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7*DIGITS-1:0]   segs_o,
  output logic                  sign_seg_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

  state_e                state_q, state_d;
  logic [BW+WIDTH-1:0]   work_q, work_d;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q, neg_d;
  logic                  done_q;
  logic                  sign_q;
  logic [7*DIGITS-1:0]   segs_q, segs_d;
  logic [BW-1:0]         bcd_adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q != IDLE);
    done_o     = done_q;
    segs_o     = segs_q;
    sign_seg_o = sign_q;
  end

  // Correct every nibble before the shift; work holds {bcd, mag} so one shift moves both.
  always_comb begin
    bcd_adj = work_q[BW+WIDTH-1:WIDTH];
    for (int i = 0; i < DIGITS; i++)
      if (work_q[WIDTH+4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = work_q[WIDTH+4*i +: 4] + 4'd3;
    work_d = {bcd_adj, work_q[WIDTH-1:0]};
  end

  assign neg_d = signed_mode_i & data_i[WIDTH-1];

  // Digits above the ones place blank while they and everything higher are zero.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    segs_d = '1;
    lead   = 1'b1;
    nib    = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = work_q[WIDTH+4*i +: 4];
      if (BLANK_LEAD != 0 && lead && nib == 4'd0 && i != 0)
        segs_d[7*i +: 7] = 7'b1111111;
      else
        segs_d[7*i +: 7] = seg7(nib);
      if (nib != 4'd0) lead = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      work_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      sign_q <= 1'b1;
      segs_q <= '1;
    end else begin
      done_q <= (state_q == UPDATE);
      case (state_q)
        IDLE: if (start_i) begin
          neg_q  <= neg_d;
          work_q <= {{BW{1'b0}}, (neg_d ? (~data_i + 1'b1) : data_i)};
          cnt_q  <= CW'(WIDTH);
        end
        SHIFT: begin
          work_q <= work_d << 1;
          cnt_q  <= cnt_q - 1'b1;
        end
        UPDATE: begin
          segs_q <= segs_d;
          sign_q <= ~neg_q;
        end
        default: ;
      endcase
    end
  end

endmodule
